// File: rtl/fetch_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | fetch_pkg                                                        |
// | Shared types and constants for the instruction-fetch stage.      |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
package fetch_pkg;

    localparam int PKG_XLEN = 32;

    localparam logic [PKG_XLEN-1:0] ADDR_ALIGN_MASK = 32'hFFFF_FFFC;

    typedef struct packed {
        logic [PKG_XLEN-1:0] pc;
        logic [PKG_XLEN-1:0] instr;
    } fetch_entry_t;

    // Width able to hold the values 0..depth inclusive.
    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// +------------------------------------------------------------------+
// | fetch_fifo                                                       |
// | Synchronous first-word fall-through FIFO with flush.             |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      push,
    input  logic                      pop,
    input  logic                      flush,
    input  logic [WIDTH-1:0]          din,
    output logic [WIDTH-1:0]          dout,
    output logic [cnt_w(DEPTH)-1:0]   count,
    output logic                      empty,
    output logic                      full
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = cnt_w(DEPTH);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_CNT_W-1:0] r_count;
    logic               w_push;
    logic               w_pop;

    assign empty = (r_count == '0);
    assign full  = (r_count == c_CNT_W'(DEPTH));
    assign count = r_count;
    assign dout  = r_mem[r_rd_ptr];

    assign w_pop  = pop && !empty;
    assign w_push = push && (!full || w_pop);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= din;
                r_wr_ptr        <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            r_count <= r_count + c_CNT_W'(w_push) - c_CNT_W'(w_pop);
        end
    end

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// +------------------------------------------------------------------+
// | fetch_unit                                                       |
// | Sequential instruction fetch with prefetch FIFO and redirects.   |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int               XLEN       = 32,
    parameter logic [XLEN-1:0]  RESET_PC   = 32'h0000_0000,
    parameter int               FIFO_DEPTH = 4,
    parameter int               PC_STEP    = 4
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_target,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_instr
);

    localparam int              CNT_W          = cnt_w(FIFO_DEPTH);
    localparam logic [CNT_W:0]  c_DEPTH_CREDIT = (CNT_W+1)'(FIFO_DEPTH);
    localparam logic [XLEN-1:0] c_STEP         = XLEN'(PC_STEP);

    logic [XLEN-1:0]   r_pc;
    logic [XLEN-1:0]   r_resp_pc;
    logic [CNT_W-1:0]  r_outstanding;
    logic [CNT_W-1:0]  r_drop_cnt;

    logic [CNT_W-1:0]  w_count;
    logic              w_empty;
    logic              w_full;
    logic [CNT_W:0]    w_credit_used;
    logic              w_req;
    logic              w_grant;
    logic              w_push;
    logic              w_pop;
    logic [XLEN-1:0]   w_target;
    logic [2*XLEN-1:0] w_fifo_dout;

    // Buffered entries plus in-flight requests never exceed the FIFO size.
    assign w_credit_used = {1'b0, w_count} + {1'b0, r_outstanding};
    assign w_req         = !reset && !redirect_valid && (w_credit_used < c_DEPTH_CREDIT);
    assign w_grant       = w_req && imem_gnt;
    assign w_target      = redirect_target & ~(XLEN'(~ADDR_ALIGN_MASK));

    assign w_pop  = !w_empty && out_ready && !redirect_valid;
    assign w_push = imem_rvalid && !redirect_valid && (r_drop_cnt == '0) && (!w_full || w_pop);

    assign imem_req  = w_req;
    assign imem_addr = r_pc;
    assign out_valid = !w_empty;
    assign {out_pc, out_instr} = w_fifo_dout;

    fetch_fifo #(
        .WIDTH (2*XLEN),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (w_push),
        .pop   (w_pop),
        .flush (redirect_valid),
        .din   ({r_resp_pc, imem_rdata}),
        .dout  (w_fifo_dout),
        .count (w_count),
        .empty (w_empty),
        .full  (w_full)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc          <= RESET_PC;
            r_resp_pc     <= RESET_PC;
            r_outstanding <= '0;
            r_drop_cnt    <= '0;
        end else begin
            r_outstanding <= r_outstanding + CNT_W'(w_grant) - CNT_W'(imem_rvalid);
            if (redirect_valid) begin
                // Every request still unreturned belongs to the wrong path.
                r_pc       <= w_target;
                r_resp_pc  <= w_target;
                r_drop_cnt <= r_outstanding - CNT_W'(imem_rvalid);
            end else begin
                if (w_grant) begin
                    r_pc <= r_pc + c_STEP;
                end
                if (imem_rvalid) begin
                    if (r_drop_cnt != '0) begin
                        r_drop_cnt <= r_drop_cnt - CNT_W'(1);
                    end else begin
                        r_resp_pc <= r_resp_pc + c_STEP;
                    end
                end
            end
        end
    end

endmodule
`default_nettype wire
